// File: rtl/word_symbol_mux.sv
`default_nettype none
// ============================================================================
//  Module      : word_symbol_mux
//  Description : Transmit-side nibble multiplexer. Accepts one DATA_W-bit
//                word over a valid/ready handshake and presents its NSYM
//                symbols (most significant nibble first) to the chip
//                spreader, advancing one slot per request strobe.
//                Optional underrun flag: define WORD_SYMBOL_MUX_UNDERRUN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module word_symbol_mux #(
    parameter int DATA_W = 16,
    parameter int SYM_W  = 4,
    parameter int NSYM   = 4,
    parameter int SEL_W  = $clog2(NSYM)
) (
    input  logic              inClk,
    input  logic              inRst,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    output logic              outReady,
    input  logic              inSymReq,
    output logic [SYM_W-1:0]  outSym,
    output logic              outSymValid,
    output logic [SEL_W-1:0]  outSel,
    output logic              outLast,
`ifdef WORD_SYMBOL_MUX_UNDERRUN_EN
    input  logic              inUnderrunClr,
    output logic              outUnderrun,
`endif
    output logic              outBusy
);

    // DATA_W is expected to equal SYM_W*NSYM; slot k covers the k-th
    // SYM_W-wide field counted from the most significant end.

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_word;

    logic                w_active;
    logic                w_last;
    logic                w_ready;
    logic                w_accept;
    logic [SYM_W-1:0]    w_slots [NSYM];

    // Slot k = word[DATA_W-1-SYM_W*k -: SYM_W]; slot 0 is the top nibble so a
    // looped-back word reassembles in the same order on the receive side.
    for (genvar k = 0; k < NSYM; k++) begin : g_slot
        assign w_slots[k] = r_word[DATA_W-1-SYM_W*k -: SYM_W];
    end

    assign w_active = (r_state == S_ACTIVE);
    assign w_last   = (r_sel == SEL_W'(NSYM - 1));

    // Ready in IDLE, or while the last symbol of the word is being consumed,
    // which lets the next word follow without a bubble.
    assign w_ready  = !w_active || (w_last && inSymReq);
    assign w_accept = inValid && w_ready;

    assign outReady    = w_ready;
    assign outSymValid = w_active;
    assign outSym      = w_active ? w_slots[r_sel] : '0;
    assign outSel      = r_sel;
    assign outLast     = w_active && w_last;
    assign outBusy     = w_active;

    // Control FSM: load on handshake, advance slot on each request, fall back
    // to IDLE after the last slot when no new word is offered.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_word  <= '0;
        end else if (w_accept) begin
            r_word  <= inData;
            r_sel   <= '0;
            r_state <= S_ACTIVE;
        end else if (w_active && inSymReq) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_sel   <= '0;
            end else begin
                r_sel   <= r_sel + SEL_W'(1);
            end
        end
    end

`ifdef WORD_SYMBOL_MUX_UNDERRUN_EN
    logic r_underrun;

    // Sticky underrun flag: a request while no symbol is live; clear wins.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_underrun <= 1'b0;
        end else if (inUnderrunClr) begin
            r_underrun <= 1'b0;
        end else if (inSymReq && !w_active) begin
            r_underrun <= 1'b1;
        end
    end

    assign outUnderrun = r_underrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_symbol_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_symbol_mux
//  Description : Self-checking bench for word_symbol_mux. A queue of pending
//                symbols serves as the reference model; directed scenarios
//                are followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_word_symbol_mux;

    logic        inClk = 1'b0;
    logic        inRst;
    logic [15:0] inData;
    logic        inValid;
    logic        outReady;
    logic        inSymReq;
    logic [3:0]  outSym;
    logic        outSymValid;
    logic [1:0]  outSel;
    logic        outLast;
    logic        outBusy;
    logic        inUnderrunClr;
`ifdef WORD_SYMBOL_MUX_UNDERRUN_EN
    logic        outUnderrun;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference model: symbols still owed for the word in flight
    logic [3:0] m_q[$];
    logic       m_und = 1'b0;
    logic       m_acc;
    // symbols seen by the spreader (sampled on each consuming request)
    logic [3:0] em[$];

    always #5 inClk = ~inClk;

    word_symbol_mux dut (
        .inClk        (inClk),
        .inRst        (inRst),
        .inData       (inData),
        .inValid      (inValid),
        .outReady     (outReady),
        .inSymReq     (inSymReq),
        .outSym       (outSym),
        .outSymValid  (outSymValid),
        .outSel       (outSel),
        .outLast      (outLast),
`ifdef WORD_SYMBOL_MUX_UNDERRUN_EN
        .inUnderrunClr(inUnderrunClr),
        .outUnderrun  (outUnderrun),
`endif
        .outBusy      (outBusy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance model, cross the edge.
    task automatic step();
        int         sz;
        logic [3:0] s0;
        logic       rdy;
        @(negedge inClk);
        sz  = m_q.size();
        s0  = (sz > 0) ? m_q[0] : 4'h0;
        rdy = (sz == 0) || (sz == 1 && inSymReq);
        chk("symValid", 32'(outSymValid), 32'(sz > 0));
        chk("sym",      32'(outSym),      32'(s0));
        chk("sel",      32'(outSel),      (sz > 0) ? 32'(4 - sz) : 32'd0);
        chk("last",     32'(outLast),     32'(sz == 1));
        chk("ready",    32'(outReady),    32'(rdy));
        chk("busy",     32'(outBusy),     32'(sz > 0));
`ifdef WORD_SYMBOL_MUX_UNDERRUN_EN
        chk("underrun", 32'(outUnderrun), 32'(m_und));
`endif
        m_acc = 1'b0;
        if (inRst) begin
            m_q.delete();
            m_und = 1'b0;
        end else begin
            if (inUnderrunClr)
                m_und = 1'b0;
            else if (inSymReq && sz == 0)
                m_und = 1'b1;
            if (inSymReq && sz > 0) begin
                em.push_back(outSym);
                void'(m_q.pop_front());
            end
            if (inValid && rdy) begin
                m_acc = 1'b1;
                for (int k = 0; k < 4; k++)
                    m_q.push_back(4'((inData >> (12 - 4 * k)) & 16'hF));
            end
        end
        @(posedge inClk);
        #1;
    endtask

    logic [3:0] exp_single [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [3:0] exp_b2b    [8] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h0, 4'hF, 4'h9, 4'h6};
    logic [3:0] exp_stall  [4] = '{4'hB, 4'hE, 4'hE, 4'hF};

    initial begin
        int nacc;
        int thr;
        inRst = 1'b1; inData = '0; inValid = 1'b0; inSymReq = 1'b0; inUnderrunClr = 1'b0;

        // reset held two cycles; only the second is checked (state unknown before)
        @(posedge inClk); #1;
        step();
        inRst = 1'b0;
        step();
        chk("rst_ready", 32'(outReady), 32'd1);

        // single word 0x1234
        em.delete();
        inData = 16'h1234; inValid = 1'b1;
        step();
        inValid = 1'b0; inSymReq = 1'b1;
        repeat (5) step();
        chk("single_n", 32'(em.size()), 32'd4);
        for (int i = 0; i < 4 && i < em.size(); i++) chk("single_sym", 32'(em[i]), 32'(exp_single[i]));

        // reset while slot 2 of 0xABCD is live
        em.delete();
        inSymReq = 1'b0; inData = 16'hABCD; inValid = 1'b1;
        step();
        inValid = 1'b0; inSymReq = 1'b1;
        step(); step();
        chk("mid_sel2", 32'(outSel), 32'd2);
        inRst = 1'b1;
        step();
        inRst = 1'b0;
        chk("mid_idle", 32'(outSymValid), 32'd0);
        repeat (3) step();
        chk("mid_n", 32'(em.size()), 32'd2);

        // back-to-back 0xA5C3, 0x0F96
        em.delete(); nacc = 0;
        inUnderrunClr = 1'b1; step(); inUnderrunClr = 1'b0;
        inData = 16'hA5C3; inValid = 1'b1; inSymReq = 1'b1;
        repeat (10) begin
            step();
            if (m_acc) begin
                nacc++;
                if (nacc == 1) inData = 16'h0F96;
                else inValid = 1'b0;
            end
        end
        chk("b2b_n", 32'(em.size()), 32'd8);
        for (int i = 0; i < 8 && i < em.size(); i++) chk("b2b_sym", 32'(em[i]), 32'(exp_b2b[i]));

        // stalled spreader: 0xBEEF, request every 4th cycle, next word waits
        em.delete();
        inSymReq = 1'b0; inData = 16'hBEEF; inValid = 1'b1;
        step();
        inData = 16'h1111;
        for (int i = 0; i < 16; i++) begin
            inSymReq = ((i % 4) == 3);
            step();
            if (i == 14) chk("stall_hold_ready", 32'(outReady), 32'd0);
        end
        chk("stall_busy", 32'(outSym), 32'h1);
        inValid = 1'b0; inSymReq = 1'b1;
        repeat (5) step();
        chk("stall_n", 32'(em.size()), 32'd8);
        for (int i = 0; i < 4 && i < em.size(); i++) chk("stall_sym", 32'(em[i]), 32'(exp_stall[i]));

        // underrun: request in IDLE, then a normal word, then clear vs. set
        inSymReq = 1'b0; inUnderrunClr = 1'b1; step(); inUnderrunClr = 1'b0;
        inSymReq = 1'b1; step();
        inSymReq = 1'b0; step();
        chk("und_idle_valid", 32'(outSymValid), 32'd0);
`ifdef WORD_SYMBOL_MUX_UNDERRUN_EN
        chk("und_set", 32'(outUnderrun), 32'd1);
`endif
        inData = 16'h5A5A; inValid = 1'b1; step();
        inValid = 1'b0; inSymReq = 1'b1; repeat (4) step();
        inSymReq = 1'b1; inUnderrunClr = 1'b1; step();
        inSymReq = 1'b0; inUnderrunClr = 1'b0; step();
`ifdef WORD_SYMBOL_MUX_UNDERRUN_EN
        chk("und_clr", 32'(outUnderrun), 32'd0);
`endif

        // randomized traffic with a well-behaved producer
        inValid = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ((c % 250) == 0) thr = int'($urandom_range(1, 4));
            if (!inValid || m_acc) begin
                inValid = ($urandom % 3) != 0;
                inData  = 16'($urandom);
            end
            inSymReq      = ($urandom % 4) < thr;
            inRst         = ($urandom % 97) == 0;
            inUnderrunClr = ($urandom % 16) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
